// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: NUM_REQ producers share one FIFO write port, bursts of up to MAX_BURST beats.
// Latency: zero added on the data path (fifo_wr_en/fifo_data decoded combinationally from the registered grant).
// Backpressure: fifo_full holds the grant and stalls the beat counter; optional FIFO_ARB_STATS_EN adds per-producer beat counters.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   wr_data,
    output logic [NUM_REQ-1:0]              gnt,
    input  logic                            fifo_full,
    output logic                            fifo_wr_en,
    output logic [DATA_WIDTH-1:0]           fifo_data,
    output logic [NUM_REQ*CNT_WIDTH-1:0]    stat_cnt
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [PW-1:0]      ptr, ptr_nxt;
    logic [PW-1:0]      win, gidx, scan_idx;
    logic               win_vld;
    logic [BW-1:0]      beat_cnt, beat_nxt;
    logic               accept, burst_done, grant_end;

    // Binary index of the currently granted producer (grant is one-hot or zero).
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) gidx = PW'(i);
        end
    end

    assign accept     = (|(req & gnt)) & ~fifo_full;
    assign fifo_wr_en = accept;
    assign fifo_data  = (|gnt) ? wr_data[gidx*DATA_WIDTH +: DATA_WIDTH] : '0;

    // A burst holder still requesting is scanned last because ptr already points past it.
    assign burst_done = accept && (beat_cnt == BW'(MAX_BURST - 1));
    assign grant_end  = burst_done || !(|(req & gnt));

    // Round-robin scan of req starting at ptr, wrapping; first asserted request wins.
    always_comb begin
        win      = '0;
        win_vld  = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = PW'((int'(ptr) + k) % NUM_REQ);
            if (!win_vld && req[scan_idx]) begin
                win_vld = 1'b1;
                win     = scan_idx;
            end
        end
    end

    // Next-state, next-grant, pointer and burst-count decode.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        beat_nxt  = beat_cnt;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = GRANT;
                    gnt_nxt   = NUM_REQ'(1) << win;
                    ptr_nxt   = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    beat_nxt  = '0;
                end
            end
            GRANT: begin
                if (grant_end) begin
                    beat_nxt = '0;
                    if (win_vld) begin
                        gnt_nxt = NUM_REQ'(1) << win;
                        ptr_nxt = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                    end
                end else if (accept) begin
                    beat_nxt = beat_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                beat_nxt  = '0;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            ptr      <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            ptr      <= ptr_nxt;
            beat_cnt <= beat_nxt;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ*CNT_WIDTH-1:0] stat_q;

    // Saturating per-producer accepted-beat counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept && gnt[i] && (stat_q[i*CNT_WIDTH +: CNT_WIDTH] != {CNT_WIDTH{1'b1}}))
                    stat_q[i*CNT_WIDTH +: CNT_WIDTH] <= stat_q[i*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
            end
        end
    end

    assign stat_cnt = stat_q;
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer model drives req/wr_data, expected writes are queued per scenario.
// A negedge monitor pops and compares every FIFO write (data and grant).
// Directed scenarios: single burst, 4-way round robin, long solo burst, fifo_full stall, reset mid-burst, stats.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int CW = 16;
`ifdef FIFO_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NR-1:0]      req = '0;
    logic [NR*DW-1:0]   wr_data = '0;
    logic [NR-1:0]      gnt;
    logic               fifo_full = 1'b0;
    logic               fifo_wr_en;
    logic [DW-1:0]      fifo_data;
    logic [NR*CW-1:0]   stat_cnt;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(4), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .wr_data    (wr_data),
        .gnt        (gnt),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .stat_cnt   (stat_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          stalls = 0;
    int          wr_total = 0;
    int          rem   [NR];
    logic [7:0]  pdata [NR];
    logic [11:0] expq  [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every FIFO write must match the head of the expected queue.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (fifo_wr_en === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h required=none at %0t", fifo_data, $time);
                end else begin
                    e = expq.pop_front();
                    chk("wr_data", 64'(fifo_data), 64'(e[7:0]));
                    chk("wr_gnt", 64'(gnt), 64'(e[11:8]));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req[i] = (rem[i] > 0);
            wr_data[i*DW +: DW] = pdata[i];
        end
    endtask

    task automatic push_run(input logic [3:0] g, input logic [7:0] base, input int n);
        for (int k = 0; k < n; k++) expq.push_back({g, 8'(base + k)});
    endtask

    // One clock: sample at negedge, then after the edge update the producer model.
    task automatic step();
        logic          acc;
        logic [NR-1:0] g;
        @(negedge clk);
        acc = fifo_wr_en;
        g   = gnt;
        if (req != '0 && !fifo_full && !fifo_wr_en) stalls++;
        @(posedge clk);
        #1;
        if (acc === 1'b1 && !rst) begin
            for (int i = 0; i < NR; i++) begin
                if (g[i] && rem[i] > 0) begin
                    rem[i]--;
                    pdata[i] = pdata[i] + 8'd1;
                    wr_total++;
                end
            end
        end
        drive();
    endtask

    function automatic bit busy();
        bit b = 1'b0;
        for (int i = 0; i < NR; i++) if (rem[i] > 0) b = 1'b1;
        return b;
    endfunction

    task automatic run_until_done(input string name);
        int n = 0;
        while (busy() && n < 300) begin
            step();
            n++;
        end
        if (busy()) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=%0d required=<300 cycles", name, n);
        end
        step();
        chk({name, "_gnt_idle"}, 64'(gnt), 64'd0);
        chk({name, "_queue_empty"}, 64'(expq.size()), 64'd0);
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst = 1'b1;
        fifo_full = 1'b0;
        for (int i = 0; i < NR; i++) begin
            rem[i]   = 0;
            pdata[i] = 8'h00;
        end
        drive();
        #1;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
        chk("rst_data", 64'(fifo_data), 64'd0);
        chk("rst_stat", 64'(stat_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stalls = 0;
        wr_total = 0;
    endtask

    task automatic check_stats(input int s0, input int s1, input int s2, input int s3);
        logic [63:0] e;
        e = STATS ? {16'(s3), 16'(s2), 16'(s1), 16'(s0)} : 64'd0;
        chk("stat_cnt", 64'(stat_cnt), e);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            rem[i]   = 0;
            pdata[i] = 8'h00;
        end

        // 1: single producer, constant data A5 for 3 beats.
        reset_dut();
        rem[1] = 3; pdata[1] = 8'hA5;
        for (int k = 0; k < 3; k++) expq.push_back({4'b0010, 8'hA5});
        drive();
        step();
        chk("s1_first_gnt", 64'(gnt), 64'b0010);
        // constant data: undo the model's increment so every beat is A5
        while (busy()) begin
            pdata[1] = 8'hA5;
            drive();
            step();
        end
        step();
        chk("s1_gnt_idle", 64'(gnt), 64'd0);
        chk("s1_queue_empty", 64'(expq.size()), 64'd0);
        chk("s1_stalls", 64'(stalls), 64'd1);
        check_stats(0, 3, 0, 0);

        // 2: all four requesting, grant order 0,1,2,3,0 with 4 beats each.
        reset_dut();
        rem[0] = 8; rem[1] = 4; rem[2] = 4; rem[3] = 4;
        pdata[0] = 8'h80; pdata[1] = 8'h90; pdata[2] = 8'hA0; pdata[3] = 8'hB0;
        push_run(4'b0001, 8'h80, 4);
        push_run(4'b0010, 8'h90, 4);
        push_run(4'b0100, 8'hA0, 4);
        push_run(4'b1000, 8'hB0, 4);
        push_run(4'b0001, 8'h84, 4);
        drive();
        run_until_done("s2");
        chk("s2_stalls", 64'(stalls), 64'd1);
        check_stats(8, 4, 4, 4);

        // 3: producer 2 alone for 10 beats; grant never drops between bursts.
        reset_dut();
        rem[2] = 10; pdata[2] = 8'hC0;
        push_run(4'b0100, 8'hC0, 10);
        drive();
        run_until_done("s3");
        chk("s3_stalls", 64'(stalls), 64'd1);
        check_stats(0, 0, 10, 0);

        // 4: two producers, FIFO full for 5 cycles after 8 writes.
        reset_dut();
        rem[0] = 6; rem[1] = 6;
        pdata[0] = 8'h10; pdata[1] = 8'h20;
        push_run(4'b0001, 8'h10, 4);
        push_run(4'b0010, 8'h20, 4);
        push_run(4'b0001, 8'h14, 2);
        push_run(4'b0010, 8'h24, 2);
        drive();
        for (int n = 0; n < 50 && wr_total < 8; n++) step();
        chk("s4_eight_written", 64'(wr_total), 64'd8);
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("s4_full_gnt", 64'(gnt), 64'b0001);
            chk("s4_full_wr_en", 64'(fifo_wr_en), 64'd0);
        end
        fifo_full = 1'b0;
        #1;
        chk("s4_resume_wr_en", 64'(fifo_wr_en), 64'd1);
        run_until_done("s4");
        chk("s4_stalls", 64'(stalls), 64'd2);
        check_stats(6, 6, 0, 0);

        // 5: reset mid-burst with beat_cnt=2 on producer 3.
        reset_dut();
        rem[3] = 4; pdata[3] = 8'h30;
        push_run(4'b1000, 8'h30, 2);
        drive();
        step();
        step();
        step();
        chk("s5_pre_gnt", 64'(gnt), 64'b1000);
        chk("s5_pre_wr_en", 64'(fifo_wr_en), 64'd1);
        rst = 1'b1;
        #1;
        chk("s5_rst_gnt", 64'(gnt), 64'd0);
        chk("s5_rst_wr_en", 64'(fifo_wr_en), 64'd0);
        chk("s5_rst_stat", 64'(stat_cnt), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stalls = 0;
        rem[1] = 1; pdata[1] = 8'h40;
        push_run(4'b0010, 8'h40, 1);
        push_run(4'b1000, 8'h32, 2);
        drive();
        run_until_done("s5");
        chk("s5_stalls", 64'(stalls), 64'd2);
        check_stats(0, 1, 0, 2);

        // 6: 32 beats round robin, 8 per producer.
        reset_dut();
        for (int i = 0; i < NR; i++) rem[i] = 8;
        pdata[0] = 8'h80; pdata[1] = 8'h90; pdata[2] = 8'hA0; pdata[3] = 8'hB0;
        push_run(4'b0001, 8'h80, 4);
        push_run(4'b0010, 8'h90, 4);
        push_run(4'b0100, 8'hA0, 4);
        push_run(4'b1000, 8'hB0, 4);
        push_run(4'b0001, 8'h84, 4);
        push_run(4'b0010, 8'h94, 4);
        push_run(4'b0100, 8'hA4, 4);
        push_run(4'b1000, 8'hB4, 4);
        drive();
        run_until_done("s6");
        chk("s6_stalls", 64'(stalls), 64'd1);
        check_stats(8, 8, 8, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
